rf_access_arbiter: RTL
======================

RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, register-file data width.
REQ-002 Parameter ADDR_WIDTH, 5, register-file address width.
REQ-003 Parameter NUM_REQ, 4, number of read requesters (2..8).
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port resetn  in  1  reset, asynchronous and active-low.
REQ-006 Port req_valid  in  NUM_REQ  per-requester read request.
REQ-007 Port req_addr  in  NUM_REQ*ADDR_WIDTH  read addresses; requester i uses slice i.
REQ-008 Port req_ready  out  NUM_REQ  grant; the request is accepted when valid and ready are both high.
REQ-009 Port resp_valid  out  NUM_REQ  read data valid for requester i.
REQ-010 Port resp_data  out  NUM_REQ*DATA_WIDTH  read data; requester i uses slice i.
REQ-011 Port wr_valid / wr_addr / wr_data  in  1 / ADDR_WIDTH / DATA_WIDTH  single write requester.
REQ-012 Port wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
REQ-013 Port rf_wen1, rf_wad1, rf_din  out  1, ADDR_WIDTH, DATA_WIDTH  register-file write port drive.
REQ-014 Port rf_ren1, rf_rad1, rf_ren2, rf_rad2  out  1, ADDR_WIDTH each  register-file read port drive.
REQ-015 Port rf_dout1, rf_dout2, rf_collision  in  DATA_WIDTH, DATA_WIDTH, 1  register-file read data and collision flag.
REQ-016 Port err_collision  out  1  sticky error: rf_collision was seen high.

Function
REQ-017 All rf_* outputs and req_ready/wr_ready SHALL be combinational from the current inputs and state; the register file samples them at the next rising edge.
REQ-018 Register-file read data SHALL be taken as valid in the cycle after rf_renN was sampled high.
REQ-019 Write: wr_ready = 1 unless the hold flag is set; on acceptance, rf_wen1=1, rf_wad1=wr_addr, rf_din=wr_data; otherwise rf_wen1=0.
REQ-020 Eligible read: req_valid[i]=1, and req_addr[i] differs from wr_addr whenever a write is accepted in the same cycle.
REQ-021 Scan order: round-robin from pointer rr_ptr through NUM_REQ indices with wrap-around.
REQ-022 Port 1 SHALL take the first eligible requester; port 2 SHALL take the next eligible requester whose address differs from port 1's address.
REQ-023 An eligible requester that matches port 1's address, or is beyond the second grant, SHALL be deferred with req_ready=0.
REQ-024 Granted requesters SHALL get req_ready=1; at most 2 grants per cycle; unused ports SHALL have rf_renN=0 and rf_radN=0.
REQ-025 rr_ptr SHALL advance to (last granted index + 1) mod NUM_REQ, and SHALL stay unchanged when there is no grant.
REQ-026 Response: a requester granted at cycle t SHALL get resp_valid[i]=1 at t+1 with the data of its port (rf_dout1 or rf_dout2), routed by a registered port-to-requester tag.
REQ-027 resp_valid SHALL be a one-cycle pulse per grant; back-to-back grants to the same requester SHALL give back-to-back pulses.
REQ-028 Hazard hold: when a read is excluded only by the write-address match, the hold flag SHALL be set for the next cycle, forcing wr_ready=0 there; the flag clears after that one cycle.
REQ-029 The two grants SHALL never share an address, and no read SHALL match an accepted write address.
REQ-030 err_collision SHALL set on any cycle with rf_collision=1 and SHALL stay set until reset.

Reset
REQ-031 With resetn low: rr_ptr=0, hold=0, tags cleared, resp_valid=0, resp_data=0, err_collision=0, all rf_ren*/rf_wen1=0, and req_ready=0, wr_ready=0 (asynchronous assert).
REQ-032 Reset asserted mid-operation SHALL drop pending responses; after release, operation SHALL resume on the first rising edge with resetn high.

Verification
REQ-033 Write addr 5 = 0xA5A50001, then requester 0 reads addr 5 -> resp_valid[0] one cycle after grant, resp_data[0]=0xA5A50001.
REQ-034 All 4 requesters valid on distinct addrs 1..4 with rr_ptr=0 -> cycle 1 grants 0,1; cycle 2 grants 2,3; rr_ptr returns to 0.
REQ-035 Requesters 0 and 1 both read addr 5 -> only 0 granted (port 1) and 1 deferred; next cycle 1 granted; rf_collision stays 0.
REQ-036 Write addr 5 = 0x12345678 plus requester 0 reading addr 5 in the same cycle -> read deferred, next cycle wr_ready=0, read granted, data=0x12345678.
REQ-037 Force rf_collision=1 for one cycle -> err_collision=1 and held; resetn pulse low -> err_collision=0 and all outputs at reset values.
REQ-038 Assert resetn low the cycle after a grant -> no resp_valid pulse emitted.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin arbitration of NUM_REQ readers and one writer onto a 2R1W register file
module rf_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data,
    input  logic                             wr_valid,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             wr_ready,
    output logic                             rf_wen1,
    output logic [ADDR_WIDTH-1:0]            rf_wad1,
    output logic [DATA_WIDTH-1:0]            rf_din,
    output logic                             rf_ren1,
    output logic [ADDR_WIDTH-1:0]            rf_rad1,
    output logic                             rf_ren2,
    output logic [ADDR_WIDTH-1:0]            rf_rad2,
    input  logic [DATA_WIDTH-1:0]            rf_dout1,
    input  logic [DATA_WIDTH-1:0]            rf_dout2,
    input  logic                             rf_collision,
    output logic                             err_collision
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] a [NUM_REQ];
    logic [PW-1:0]         sc [NUM_REQ];
    logic [NUM_REQ-1:0]    elig, haz;
    logic [PW-1:0]         rr_ptr, g1, g2, t1, t2, nxt;
    logic                  f1, f2, v1, v2, hold, wr_acc;

    assign wr_ready = resetn && !hold;
    assign wr_acc   = wr_ready && wr_valid;
    assign rf_wen1  = wr_acc;
    assign rf_wad1  = wr_acc ? wr_addr : '0;
    assign rf_din   = wr_acc ? wr_data : '0;

    genvar i, k;
    for (i = 0; i < NUM_REQ; i++) begin : g_req
        assign a[i]    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign haz[i]  = req_valid[i] && wr_acc && a[i] == wr_addr;
        assign elig[i] = resetn && req_valid[i] && !haz[i];
    end

    // scan order starting at the round-robin pointer
    for (k = 0; k < NUM_REQ; k++) begin : g_scan
        assign sc[k] = PW'((int'(rr_ptr) + k) % NUM_REQ);
    end

    always_comb begin
        f1 = 1'b0;
        f2 = 1'b0;
        g1 = '0;
        g2 = '0;
        req_ready = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (elig[sc[n]]) begin
                if (!f1) begin
                    f1 = 1'b1;
                    g1 = sc[n];
                end else if (!f2 && a[sc[n]] != a[g1]) begin
                    f2 = 1'b1;
                    g2 = sc[n];
                end
            end
        end
        if (f1) req_ready[g1] = 1'b1;
        if (f2) req_ready[g2] = 1'b1;
    end

    assign rf_ren1 = f1;
    assign rf_rad1 = f1 ? a[g1] : '0;
    assign rf_ren2 = f2;
    assign rf_rad2 = f2 ? a[g2] : '0;
    assign nxt     = PW'((int'(f2 ? g2 : g1) + 1) % NUM_REQ);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr        <= '0;
            hold          <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            t1            <= '0;
            t2            <= '0;
            err_collision <= 1'b0;
        end else begin
            if (f1) rr_ptr <= nxt;
            hold          <= |haz;
            v1            <= f1;
            v2            <= f2;
            t1            <= g1;
            t2            <= g2;
            err_collision <= err_collision || rf_collision;
        end
    end

    // read data returns one cycle after the grant; tags route each port back to its requester
    for (i = 0; i < NUM_REQ; i++) begin : g_resp
        logic h1, h2;
        assign h1 = v1 && t1 == PW'(i);
        assign h2 = v2 && t2 == PW'(i);
        assign resp_valid[i] = h1 || h2;
        assign resp_data[i*DATA_WIDTH +: DATA_WIDTH] = h1 ? rf_dout1 : h2 ? rf_dout2 : '0;
    end
endmodule
